// File: rtl/esc_pkg.sv
// Shared constants and the pulse-width helper for the multi-channel ESC PWM generator.
package esc_pkg;

  localparam int unsigned DEF_NUM_CH         = 4;
  localparam int unsigned DEF_SPEED_W        = 11;
  localparam int unsigned DEF_MIN_PULSE      = 6250;
  localparam int unsigned DEF_GAIN           = 3;
  localparam int unsigned DEF_MAX_SPEED      = 2047;
  localparam int unsigned DEF_PERIOD_CYC     = 25000;
  localparam int unsigned DEF_TIMEOUT_FRAMES = 8;

  // High time in clk cycles for a given (already saturated) speed command.
  function automatic int unsigned pulse_len(
    input int unsigned speed,
    input int unsigned min_pulse = DEF_MIN_PULSE,
    input int unsigned gain      = DEF_GAIN
  );
    return min_pulse + gain * speed;
  endfunction

endpackage

// File: rtl/esc_pwm_chan.sv
// One ESC channel: saturating speed capture, double-buffered pend/active
// speeds, and the pulse comparator driving the registered PWM pin.
module esc_pwm_chan
  import esc_pkg::*;
#(
  parameter int unsigned SPEED_W   = DEF_SPEED_W,
  parameter int unsigned MIN_PULSE = DEF_MIN_PULSE,
  parameter int unsigned GAIN      = DEF_GAIN,
  parameter int unsigned MAX_SPEED = DEF_MAX_SPEED,
  parameter int unsigned CNT_W     = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wrt,
  input  logic [SPEED_W-1:0] speed,
  input  logic [CNT_W-1:0]   cnt,
  input  logic               load,
  input  logic               force_idle,
  output logic               pwm
);

  localparam logic [SPEED_W-1:0] SAT_MAX = SPEED_W'(MAX_SPEED);

  logic [SPEED_W-1:0] sat_s;
  logic [SPEED_W-1:0] pend_d, pend_q;
  logic [SPEED_W-1:0] active_d, active_q;
  logic [SPEED_W-1:0] eff_s;
  logic [CNT_W-1:0]   pulse_s;
  logic               pwm_d, pwm_q;

  // Clip the command, stage it in pend, and hand it to active at the frame load
  // (a write landing on the load cycle bypasses pend so it is not lost).
  always_comb begin
    if (speed > SAT_MAX) begin
      sat_s = SAT_MAX;
    end else begin
      sat_s = speed;
    end
    if (wrt) begin
      pend_d = sat_s;
    end else begin
      pend_d = pend_q;
    end
    if (load) begin
      if (wrt) begin
        active_d = sat_s;
      end else begin
        active_d = pend_q;
      end
    end else begin
      active_d = active_q;
    end
  end

  // Pulse compare; once the pin has fallen in a frame it stays low until the
  // next frame start, so late arm/timeout changes can only shorten a pulse.
  always_comb begin
    if (force_idle) begin
      eff_s = '0;
    end else begin
      eff_s = active_q;
    end
    pulse_s = CNT_W'(pulse_len(32'(eff_s), MIN_PULSE, GAIN));
    if (cnt == '0) begin
      pwm_d = (cnt < pulse_s);
    end else if (pwm_q) begin
      pwm_d = (cnt < pulse_s);
    end else begin
      pwm_d = 1'b0;
    end
  end

  // Channel state registers; reset drops the pin immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q   <= '0;
      active_q <= '0;
      pwm_q    <= 1'b0;
    end else begin
      pend_q   <= pend_d;
      active_q <= active_d;
      pwm_q    <= pwm_d;
    end
  end

  assign pwm = pwm_q;

endmodule

// File: rtl/esc_pwm_multi.sv
// Frame-synchronous multi-channel ESC PWM generator: shared frame counter,
// command-timeout failsafe and frame-start strobe, one esc_pwm_chan per motor.
module esc_pwm_multi
  import esc_pkg::*;
#(
  parameter int unsigned NUM_CH         = DEF_NUM_CH,
  parameter int unsigned SPEED_W        = DEF_SPEED_W,
  parameter int unsigned MIN_PULSE      = DEF_MIN_PULSE,
  parameter int unsigned GAIN           = DEF_GAIN,
  parameter int unsigned MAX_SPEED      = DEF_MAX_SPEED,
  parameter int unsigned PERIOD_CYC     = DEF_PERIOD_CYC,
  parameter int unsigned TIMEOUT_FRAMES = DEF_TIMEOUT_FRAMES
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_CH-1:0]         wrt,
  input  logic [NUM_CH*SPEED_W-1:0] SPEED,
  input  logic                      arm,
  output logic [NUM_CH-1:0]         PWM,
  output logic                      frm_start,
  output logic                      timed_out
);

  localparam int unsigned        CNT_W    = $clog2(PERIOD_CYC);
  localparam int unsigned        TO_W     = $clog2(TIMEOUT_FRAMES + 1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(PERIOD_CYC - 1);
  localparam logic [TO_W-1:0]    TO_MAX   = TO_W'(TIMEOUT_FRAMES);

  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             load_s;
  logic             any_wrt_s;
  logic             force_idle_s;
  logic [TO_W-1:0]  tout_d, tout_q;
  logic             timed_out_d, timed_out_q;
  logic             wrt_seen_d, wrt_seen_q;
  logic             frm_start_d, frm_start_q;

  // Frame counter wraps at PERIOD_CYC-1; that last cycle is the frame load.
  always_comb begin
    load_s = (cnt_q == CNT_LAST);
    if (load_s) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    frm_start_d = (cnt_q == '0);
  end

  // Failsafe: count frame loads with no write since the previous load,
  // saturate at TIMEOUT_FRAMES and force idle; any write clears it at once.
  always_comb begin
    any_wrt_s   = |wrt;
    tout_d      = tout_q;
    timed_out_d = timed_out_q;
    if (any_wrt_s) begin
      tout_d      = '0;
      timed_out_d = 1'b0;
    end else if (load_s && !wrt_seen_q) begin
      if (tout_q != TO_MAX) begin
        tout_d = tout_q + TO_W'(1);
      end else begin
        tout_d = tout_q;
      end
      if (tout_d == TO_MAX) begin
        timed_out_d = 1'b1;
      end else begin
        timed_out_d = timed_out_q;
      end
    end else begin
      tout_d      = tout_q;
      timed_out_d = timed_out_q;
    end
    // A write on the load cycle is credited to that load, not the next one.
    if (load_s) begin
      wrt_seen_d = 1'b0;
    end else if (any_wrt_s) begin
      wrt_seen_d = 1'b1;
    end else begin
      wrt_seen_d = wrt_seen_q;
    end
    force_idle_s = !arm || timed_out_q;
  end

  // Shared frame and failsafe registers; out of reset the outputs idle until a write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      tout_q      <= '0;
      timed_out_q <= 1'b1;
      wrt_seen_q  <= 1'b0;
      frm_start_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      tout_q      <= tout_d;
      timed_out_q <= timed_out_d;
      wrt_seen_q  <= wrt_seen_d;
      frm_start_q <= frm_start_d;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    esc_pwm_chan #(
      .SPEED_W   (SPEED_W),
      .MIN_PULSE (MIN_PULSE),
      .GAIN      (GAIN),
      .MAX_SPEED (MAX_SPEED),
      .CNT_W     (CNT_W)
    ) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .wrt        (wrt[i]),
      .speed      (SPEED[i*SPEED_W +: SPEED_W]),
      .cnt        (cnt_q),
      .load       (load_s),
      .force_idle (force_idle_s),
      .pwm        (PWM[i])
    );
  end

  assign frm_start = frm_start_q;
  assign timed_out = timed_out_q;

endmodule

// File: tb/tb_esc_pwm_multi.sv
// Self-checking bench for esc_pwm_multi using a scaled-down frame so many
// frames fit in a short run. The reference model works per frame: it predicts
// each channel's high time from the pend/active/timeout rules.
module tb_esc_pwm_multi;

  localparam int NUM_CH  = 4;
  localparam int SPEED_W = 6;
  localparam int MIN_P   = 40;
  localparam int GAIN    = 3;
  localparam int MAX_SPD = 50;
  localparam int P       = 200;
  localparam int TOF     = 8;
  localparam int SPW     = NUM_CH * SPEED_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NUM_CH-1:0] wrt;
  logic [SPW-1:0]    SPEED;
  logic              arm;
  logic [NUM_CH-1:0] PWM;
  logic              frm_start;
  logic              timed_out;

  int checks   = 0;
  int failures = 0;

  // reference model state
  int m_pend[NUM_CH];
  int m_active[NUM_CH];
  int m_tcnt;
  bit m_to;
  int exp_w[NUM_CH];
  // measured per-frame results
  int dut_w[NUM_CH];
  int dut_tot[NUM_CH];
  bit fs_ok;

  esc_pwm_multi #(
    .NUM_CH(NUM_CH), .SPEED_W(SPEED_W), .MIN_PULSE(MIN_P), .GAIN(GAIN),
    .MAX_SPEED(MAX_SPD), .PERIOD_CYC(P), .TIMEOUT_FRAMES(TOF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wrt(wrt), .SPEED(SPEED), .arm(arm),
    .PWM(PWM), .frm_start(frm_start), .timed_out(timed_out)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_pend[i]   = 0;
      m_active[i] = 0;
    end
    m_tcnt = 0;
    m_to   = 1'b1;
  endtask

  // Predict widths for one frame, then advance the model over its frame load.
  task automatic model_frame(input logic [NUM_CH-1:0] wm, input int wp,
                             input logic [SPW-1:0] sp, input bit a0, input int ap);
    for (int i = 0; i < NUM_CH; i++) begin
      exp_w[i] = 0;
      for (int c = 0; c < P; c++) begin
        bit a;
        bit to;
        int eff;
        a   = (c < ap) ? a0 : !a0;
        to  = m_to && !((wm != '0) && (wp < c));
        eff = (a && !to) ? m_active[i] : 0;
        if ((c < MIN_P + GAIN * eff) && (exp_w[i] == c)) exp_w[i]++;
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (wm[i]) begin
        int s;
        s = int'(sp[i*SPEED_W +: SPEED_W]);
        m_pend[i] = (s > MAX_SPD) ? MAX_SPD : s;
      end
      m_active[i] = m_pend[i];
    end
    if (wm != '0) begin
      m_tcnt = 0;
      m_to   = 1'b0;
    end else begin
      if (m_tcnt < TOF) m_tcnt++;
      if (m_tcnt == TOF) m_to = 1'b1;
    end
  endtask

  // Drive one full frame (entered with the DUT counter at 0) and measure it.
  task automatic run_frame(input logic [NUM_CH-1:0] wm, input int wp,
                           input logic [SPW-1:0] sp, input bit a0, input int ap);
    fs_ok = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      dut_w[i]   = 0;
      dut_tot[i] = 0;
    end
    for (int c = 0; c < P; c++) begin
      wrt   = (c == wp) ? wm : '0;
      SPEED = sp;
      arm   = (c < ap) ? a0 : !a0;
      @(posedge clk);
      @(negedge clk);
      if (frm_start !== (c == 0)) fs_ok = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        if (PWM[i] === 1'b1) begin
          dut_tot[i]++;
          if (dut_w[i] == c) dut_w[i]++;
        end
      end
    end
    wrt = '0;
  endtask

  task automatic frame(input logic [NUM_CH-1:0] wm, input int wp,
                       input logic [SPW-1:0] sp, input bit a0, input int ap);
    model_frame(wm, wp, sp, a0, ap);
    run_frame(wm, wp, sp, a0, ap);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    wrt   = '0;
    SPEED = '0;
    arm   = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic release_reset();
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (PWM !== 4'h0 || frm_start !== 1'b0 || timed_out !== 1'b1) begin
      failures++;
      $display("FAIL reset_vals pwm=%h fs=%b to=%b want pwm=0 fs=0 to=1", PWM, frm_start, timed_out);
    end
    release_reset();
    for (int f = 0; f < 2; f++) begin
      frame('0, 0, '0, 1'b1, P);
      for (int i = 0; i < NUM_CH; i++) begin
        checks++;
        if (dut_w[i] !== MIN_P || dut_tot[i] !== MIN_P) begin
          failures++;
          $display("FAIL reset_idle ch%0d width=%0d total=%0d want %0d", i, dut_w[i], dut_tot[i], MIN_P);
        end
      end
      checks++;
      if (!fs_ok || timed_out !== 1'b1) begin
        failures++;
        $display("FAIL reset_frame fs_ok=%b to=%b want fs_ok=1 to=1", fs_ok, timed_out);
      end
    end
  endtask

  task automatic test_single_write();
    logic [SPW-1:0] sp;
    sp = '0;
    sp[0 +: SPEED_W] = 6'd63;
    frame(4'b0001, 100, sp, 1'b1, P);
    checks++;
    if (dut_w[0] !== MIN_P || dut_tot[0] !== MIN_P) begin
      failures++;
      $display("FAIL write_same_frame width=%0d want %0d", dut_w[0], MIN_P);
    end
    frame('0, 0, '0, 1'b1, P);
    checks++;
    if (dut_w[0] !== 190 || dut_tot[0] !== 190) begin
      failures++;
      $display("FAIL write_clip ch0 width=%0d want 190", dut_w[0]);
    end
    for (int i = 1; i < NUM_CH; i++) begin
      checks++;
      if (dut_w[i] !== MIN_P) begin
        failures++;
        $display("FAIL write_other ch%0d width=%0d want %0d", i, dut_w[i], MIN_P);
      end
    end
    checks++;
    if (timed_out !== 1'b0) begin
      failures++;
      $display("FAIL write_clears_to to=%b want 0", timed_out);
    end
  endtask

  task automatic test_load_edge();
    logic [SPW-1:0] sp;
    sp = '0;
    sp[SPEED_W +: SPEED_W] = 6'd10;
    frame(4'b0010, P - 1, sp, 1'b1, P);
    checks++;
    if (dut_w[1] !== MIN_P) begin
      failures++;
      $display("FAIL load_edge_cur ch1 width=%0d want %0d", dut_w[1], MIN_P);
    end
    for (int f = 0; f < 2; f++) begin
      frame('0, 0, '0, 1'b1, P);
      checks++;
      if (dut_w[1] !== 70 || dut_tot[1] !== 70) begin
        failures++;
        $display("FAIL load_edge_next f%0d ch1 width=%0d want 70", f, dut_w[1]);
      end
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 20; f++) begin
      logic [NUM_CH-1:0] wm;
      logic [SPW-1:0]    sp;
      int wp;
      int ap;
      bit a0;
      wm = (($urandom % 4) == 0) ? '0 : NUM_CH'($urandom);
      wp = (($urandom % 5) == 0) ? P - 1 : int'($urandom_range(0, P - 1));
      sp = SPW'($urandom);
      a0 = (($urandom % 8) != 0);
      ap = (($urandom % 3) == 0) ? int'($urandom_range(1, P - 1)) : P;
      frame(wm, wp, sp, a0, ap);
      for (int i = 0; i < NUM_CH; i++) begin
        checks++;
        if (dut_w[i] !== exp_w[i] || dut_tot[i] !== exp_w[i]) begin
          failures++;
          $display("FAIL random f%0d ch%0d width=%0d total=%0d want %0d", f, i, dut_w[i], dut_tot[i], exp_w[i]);
        end
      end
      checks++;
      if (!fs_ok || timed_out !== m_to) begin
        failures++;
        $display("FAIL random_frame f%0d fs_ok=%b to=%b want fs_ok=1 to=%b", f, fs_ok, timed_out, m_to);
      end
    end
  endtask

  task automatic test_arm();
    logic [SPW-1:0] sp;
    sp = {6'd63, 6'd0, 6'd20, 6'd50};
    frame(4'hF, 5, sp, 1'b1, P);
    frame('0, 0, '0, 1'b1, 60);
    for (int i = 0; i < NUM_CH; i++) begin
      int want;
      want = (i == 2) ? MIN_P : 60;
      checks++;
      if (dut_w[i] !== want || dut_tot[i] !== want) begin
        failures++;
        $display("FAIL arm_drop ch%0d width=%0d want %0d", i, dut_w[i], want);
      end
    end
    frame('0, 0, '0, 1'b0, 100);
    for (int i = 0; i < NUM_CH; i++) begin
      checks++;
      if (dut_w[i] !== MIN_P || dut_tot[i] !== MIN_P) begin
        failures++;
        $display("FAIL arm_rise_no_reextend ch%0d width=%0d total=%0d want %0d", i, dut_w[i], dut_tot[i], MIN_P);
      end
    end
  endtask

  task automatic test_timeout();
    logic [SPW-1:0] sp;
    sp = {6'd30, 6'd30, 6'd30, 6'd30};
    frame(4'hF, 50, sp, 1'b1, P);
    for (int f = 1; f <= TOF + 1; f++) begin
      frame('0, 0, '0, 1'b1, P);
      checks++;
      if (timed_out !== (f >= TOF)) begin
        failures++;
        $display("FAIL timeout_flag load%0d to=%b want %b", f, timed_out, (f >= TOF));
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      checks++;
      if (dut_w[i] !== MIN_P) begin
        failures++;
        $display("FAIL timeout_idle ch%0d width=%0d want %0d", i, dut_w[i], MIN_P);
      end
    end
    frame(4'b0100, P - 1, sp, 1'b1, P);
    checks++;
    if (timed_out !== 1'b0) begin
      failures++;
      $display("FAIL timeout_clear to=%b want 0", timed_out);
    end
    frame('0, 0, '0, 1'b1, P);
    checks++;
    if (dut_w[0] !== 130 || dut_w[2] !== 130) begin
      failures++;
      $display("FAIL timeout_resume ch0=%0d ch2=%0d want 130", dut_w[0], dut_w[2]);
    end
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 10; c++) begin
      wrt = '0;
      arm = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    checks++;
    if (PWM !== 4'hF) begin
      failures++;
      $display("FAIL pre_reset_high pwm=%h want f", PWM);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (PWM !== 4'h0 || timed_out !== 1'b1 || frm_start !== 1'b0) begin
      failures++;
      $display("FAIL async_reset pwm=%h to=%b fs=%b want pwm=0 to=1 fs=0", PWM, timed_out, frm_start);
    end
    repeat (2) @(negedge clk);
    release_reset();
    frame(4'b0100, 5, {6'd0, 6'd1, 6'd0, 6'd0}, 1'b1, P);
    checks++;
    if (dut_w[0] !== MIN_P || dut_w[1] !== MIN_P) begin
      failures++;
      $display("FAIL reset_clears_active ch0=%0d ch1=%0d want %0d", dut_w[0], dut_w[1], MIN_P);
    end
    checks++;
    if (!fs_ok || timed_out !== 1'b0) begin
      failures++;
      $display("FAIL reset_first_write fs_ok=%b to=%b want fs_ok=1 to=0", fs_ok, timed_out);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_load_edge();
    test_random();
    test_arm();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
